// File: rtl/instruction_fetch.sv
// Fetch stage of the non-pipelined LEGv8 core: owns the PC, issues imem req/ack reads and buffers
// {pc, instr} for decode. Define IFETCH_SKID_EN for a 2-entry buffer (default is 1 entry).
module instruction_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_valid_i,
    input  logic [63:0] redirect_base_i,
    input  logic [63:0] redirect_offset_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_instr_o,
    output logic [63:0] if_pc_o
);

`ifdef IFETCH_SKID_EN
    localparam logic [1:0] Depth = 2'd2;
`else
    localparam logic [1:0] Depth = 2'd1;
`endif

    typedef enum logic {StFetch, StDiscard} state_e;

    state_e      state_q;
    logic [63:0] pc_q;
    logic        req_q;
    logic [63:0] addr_q;
    logic [1:0]  count_q;
    logic [63:0] head_pc_q;
    logic [31:0] head_instr_q;
`ifdef IFETCH_SKID_EN
    logic [63:0] tail_pc_q;
    logic [31:0] tail_instr_q;
`endif

    logic [63:0] target;
    logic        pop;
    logic        push;
    logic [1:0]  count_after_pop;

    always_comb begin
        // Shift in 64 bits drops offset[63:62]; the add wraps silently.
        target          = redirect_base_i + (redirect_offset_i << 2);
        pop             = (count_q != 2'd0) && if_ready_i;
        count_after_pop = count_q - {1'b0, pop};
        push            = req_q && imem_ack_i && (state_q == StFetch) && !redirect_valid_i;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            count_q      <= 2'd0;
            head_pc_q    <= 64'd0;
            head_instr_q <= 32'd0;
`ifdef IFETCH_SKID_EN
            tail_pc_q    <= 64'd0;
            tail_instr_q <= 32'd0;
`endif
        end else begin
            if (redirect_valid_i) begin
                count_q <= 2'd0;
            end else begin
                count_q <= count_after_pop + {1'b0, push};
`ifdef IFETCH_SKID_EN
                if (pop && (count_q == 2'd2)) begin
                    head_pc_q    <= tail_pc_q;
                    head_instr_q <= tail_instr_q;
                end
                if (push && (count_after_pop != 2'd0)) begin
                    tail_pc_q    <= addr_q;
                    tail_instr_q <= imem_rdata_i;
                end else if (push) begin
                    head_pc_q    <= addr_q;
                    head_instr_q <= imem_rdata_i;
                end
`else
                if (push) begin
                    head_pc_q    <= addr_q;
                    head_instr_q <= imem_rdata_i;
                end
`endif
            end

            unique case (state_q)
                StFetch: begin
                    if (req_q) begin
                        if (imem_ack_i) begin
                            req_q <= 1'b0;
                            pc_q  <= redirect_valid_i ? target : pc_q + 64'd4;
                        end else if (redirect_valid_i) begin
                            // Request stays held; pc_q doubles as the pending target.
                            state_q <= StDiscard;
                            pc_q    <= target;
                        end
                    end else if (redirect_valid_i) begin
                        req_q  <= 1'b1;
                        addr_q <= target;
                        pc_q   <= target;
                    end else if (count_after_pop < Depth) begin
                        req_q  <= 1'b1;
                        addr_q <= pc_q;
                    end
                end
                StDiscard: begin
                    if (redirect_valid_i) begin
                        pc_q <= target;
                    end
                    if (imem_ack_i) begin
                        req_q   <= 1'b0;
                        state_q <= StFetch;
                    end
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign if_valid_o  = (count_q != 2'd0);
    assign if_instr_o  = head_instr_q;
    assign if_pc_o     = head_pc_q;

endmodule
